// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan reader.
// Segment patterns are active-low, bit order g..a (bit6 = g, bit0 = a).
package seg7_pkg;

    localparam logic [6:0] PAT_0     = 7'b1000000;
    localparam logic [6:0] PAT_1     = 7'b1111001;
    localparam logic [6:0] PAT_2     = 7'b0100100;
    localparam logic [6:0] PAT_3     = 7'b0110000;
    localparam logic [6:0] PAT_4     = 7'b0011001;
    localparam logic [6:0] PAT_5     = 7'b0010010;
    localparam logic [6:0] PAT_6     = 7'b0000010;
    localparam logic [6:0] PAT_7     = 7'b1011000;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0010000;
    localparam logic [6:0] PAT_O     = 7'b0100011;
    localparam logic [6:0] PAT_D     = 7'b0100001;
    localparam logic [6:0] PAT_E     = 7'b0000110;
    localparam logic [6:0] PAT_N     = 7'b0101011;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_0     = 4'd0;
    localparam logic [3:0] CODE_1     = 4'd1;
    localparam logic [3:0] CODE_2     = 4'd2;
    localparam logic [3:0] CODE_3     = 4'd3;
    localparam logic [3:0] CODE_4     = 4'd4;
    localparam logic [3:0] CODE_5     = 4'd5;
    localparam logic [3:0] CODE_6     = 4'd6;
    localparam logic [3:0] CODE_7     = 4'd7;
    localparam logic [3:0] CODE_8     = 4'd8;
    localparam logic [3:0] CODE_9     = 4'd9;
    localparam logic [3:0] CODE_O     = 4'd11;
    localparam logic [3:0] CODE_D     = 4'd12;
    localparam logic [3:0] CODE_E     = 4'd13;
    localparam logic [3:0] CODE_N     = 4'd14;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment pattern -> digit code.
// Unrecognised patterns decode to blank and raise unknown.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic       unknown,
    output logic [3:0] code
);

    // Table lookup; 0010000 is always 9, so code 10 never appears.
    always_comb begin
        unknown = 1'b0;
        code    = CODE_BLANK;
        case (pat)
            PAT_0:     code = CODE_0;
            PAT_1:     code = CODE_1;
            PAT_2:     code = CODE_2;
            PAT_3:     code = CODE_3;
            PAT_4:     code = CODE_4;
            PAT_5:     code = CODE_5;
            PAT_6:     code = CODE_6;
            PAT_7:     code = CODE_7;
            PAT_8:     code = CODE_8;
            PAT_9:     code = CODE_9;
            PAT_O:     code = CODE_O;
            PAT_D:     code = CODE_D;
            PAT_E:     code = CODE_E;
            PAT_N:     code = CODE_N;
            PAT_BLANK: code = CODE_BLANK;
            default:   unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: reads a multiplexed 4-digit 7-segment display and
// reassembles whole frames once each digit has been stable for SETTLE samples.
// Optional build macro SEG7_DP_CAPTURE_EN adds the dp output and makes the
// decimal point part of the pattern comparison.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  dig_en_n,
    output logic [15:0] code,
    output logic        valid,
    input  logic        ready,
    output logic        bad,
    output logic        ovr
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [3:0]  dp
`endif
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  lat_en;
    logic [7:0]  lat_seg;
    logic [3:0]  mask;
    logic [15:0] slots;

    logic        legal;
    logic [1:0]  idx;
    logic [7:0]  smp_seg;
    logic        same;
    logic        capture;
    logic        frame_done;
    logic [3:0]  mask_after;
    logic [15:0] slots_after;
    logic        dec_unknown;
    logic [3:0]  dec_code;

`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]  slot_dp;
    logic [3:0]  dp_after;
    assign smp_seg = seg;
`else
    logic        unused_dp;
    assign unused_dp = seg[7];
    assign smp_seg   = {1'b0, seg[6:0]};
`endif

    seg7_pattern_decode u_dec (
        .pat     (seg[6:0]),
        .unknown (dec_unknown),
        .code    (dec_code)
    );

    // Sample classification and the frame contents a capture would produce.
    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        case (dig_en_n)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: legal = 1'b0;
        endcase

        same = (dig_en_n == lat_en) && (smp_seg == lat_seg);

        case (state)
            ST_IDLE:   capture = legal && (SETTLE_CNT == 8'd1);
            ST_SETTLE: capture = same && ((cnt + 8'd1) == SETTLE_CNT);
            default:   capture = 1'b0;
        endcase

        // Re-capturing an already held digit starts a fresh partial frame
        if (mask[idx]) begin
            mask_after  = 4'b0001 << idx;
            slots_after = '0;
        end else begin
            mask_after  = mask | (4'b0001 << idx);
            slots_after = slots;
        end
        slots_after[{idx, 2'b00} +: 4] = dec_code;

`ifdef SEG7_DP_CAPTURE_EN
        dp_after      = mask[idx] ? '0 : slot_dp;
        dp_after[idx] = ~seg[7];
`endif

        frame_done = capture && (mask_after == 4'b1111);
    end

    // Settle FSM, frame assembly and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lat_en  <= '1;
            lat_seg <= '0;
            mask    <= '0;
            slots   <= '0;
            code    <= '0;
            valid   <= 1'b0;
            bad     <= 1'b0;
            ovr     <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
            slot_dp <= '0;
            dp      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (legal) begin
                        lat_en  <= dig_en_n;
                        lat_seg <= smp_seg;
                        cnt     <= 8'd1;
                        state   <= capture ? ST_HOLD : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (same) begin
                        cnt <= cnt + 8'd1;
                        if (capture)
                            state <= ST_HOLD;
                    end else if (legal) begin
                        lat_en  <= dig_en_n;
                        lat_seg <= smp_seg;
                        cnt     <= 8'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (!same)
                        state <= ST_IDLE;
                end
            endcase

            if (valid && ready)
                valid <= 1'b0;

            if (capture) begin
                slots <= slots_after;
                mask  <= frame_done ? 4'b0000 : mask_after;
`ifdef SEG7_DP_CAPTURE_EN
                slot_dp <= dp_after;
`endif
                if (dec_unknown)
                    bad <= 1'b1;
                if (frame_done) begin
                    // An accept in the same cycle frees the output for the new frame
                    if (!valid || ready) begin
                        code  <= slots_after;
                        valid <= 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
                        dp    <= dp_after;
`endif
                    end else begin
                        ovr <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed, table-driven checks of seg7_scan_reader
// with SETTLE = 4.
module tb_seg7_scan_reader;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1011000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PU = 7'b1010101;

    logic        clk;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  dig_en_n;
    logic [15:0] code;
    logic        valid;
    logic        ready;
    logic        bad;
    logic        ovr;
`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]  dp;
`endif

    int unsigned n_pass;
    int unsigned n_total;

    typedef struct {
        logic [6:0] pat;
        logic [3:0] exp_code;
        logic       exp_bad;
    } vec_t;

    vec_t vecs [16];

    seg7_scan_reader #(.SETTLE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .dig_en_n (dig_en_n),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .bad      (bad),
        .ovr      (ovr)
`ifdef SEG7_DP_CAPTURE_EN
        ,
        .dp       (dp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic hold(input logic [3:0] en, input logic [7:0] s, input int n);
        dig_en_n = en;
        seg      = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input int d, input logic [6:0] p, input int n);
        logic [3:0] e;
        e = 4'b0001 << d;
        hold(~e, {1'b1, p}, n);
    endtask

    task automatic scan4(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] d);
        scan(0, a, 5);
        scan(1, b, 5);
        scan(2, c, 5);
        scan(3, d, 5);
    endtask

    task automatic accept();
        ready    = 1'b1;
        dig_en_n = 4'hF;
        @(negedge clk);
        ready    = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        dig_en_n = 4'hF;
        ready    = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        seg      = 8'hFF;
        dig_en_n = 4'hF;
        ready    = 1'b0;

        vecs[0]  = '{P0, 4'h0, 1'b0};
        vecs[1]  = '{P1, 4'h1, 1'b0};
        vecs[2]  = '{P2, 4'h2, 1'b0};
        vecs[3]  = '{P3, 4'h3, 1'b0};
        vecs[4]  = '{P4, 4'h4, 1'b0};
        vecs[5]  = '{P5, 4'h5, 1'b0};
        vecs[6]  = '{P6, 4'h6, 1'b0};
        vecs[7]  = '{P7, 4'h7, 1'b0};
        vecs[8]  = '{P8, 4'h8, 1'b0};
        vecs[9]  = '{P9, 4'h9, 1'b0};
        vecs[10] = '{7'b0100011, 4'hB, 1'b0};
        vecs[11] = '{7'b0100001, 4'hC, 1'b0};
        vecs[12] = '{7'b0000110, 4'hD, 1'b0};
        vecs[13] = '{7'b0101011, 4'hE, 1'b0};
        vecs[14] = '{7'b1111111, 4'hF, 1'b0};
        vecs[15] = '{PU, 4'hF, 1'b1};

        #1;
        chk("reset_code", code, 16'h0000);
        chk("reset_valid", {15'd0, valid}, 16'd0);
        chk("reset_bad", {15'd0, bad}, 16'd0);
        chk("reset_ovr", {15'd0, ovr}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Decode table: same pattern on all four digits
        for (int i = 0; i < 16; i++) begin
            do_reset();
            scan4(vecs[i].pat, vecs[i].pat, vecs[i].pat, vecs[i].pat);
            chk($sformatf("tbl%0d_code", i), code, {4{vecs[i].exp_code}});
            chk($sformatf("tbl%0d_valid", i), {15'd0, valid}, 16'd1);
            chk($sformatf("tbl%0d_bad", i), {15'd0, bad}, {15'd0, vecs[i].exp_bad});
        end

        // Basic frame
        do_reset();
        scan(0, P0, 5);
        scan(1, P1, 5);
        scan(2, P2, 5);
        chk("basic_not_yet", {15'd0, valid}, 16'd0);
        scan(3, P3, 5);
        chk("basic_valid", {15'd0, valid}, 16'd1);
        chk("basic_code", code, 16'h3210);
        chk("basic_bad", {15'd0, bad}, 16'd0);
        accept();
        chk("basic_accept", {15'd0, valid}, 16'd0);

        // Digit 2 too short to settle
        scan(0, P0, 5);
        scan(1, P1, 5);
        scan(2, P2, 3);
        scan(3, P3, 5);
        chk("short_no_valid", {15'd0, valid}, 16'd0);
        scan4(P5, P6, P7, P8);
        chk("short_next_valid", {15'd0, valid}, 16'd1);
        chk("short_next_code", code, 16'h8765);
        accept();

        // Illegal enables never select a digit
        hold(4'b0000, {1'b1, P9}, 8);
        hold(4'b1100, {1'b1, P9}, 8);
        scan(1, P1, 5);
        scan(2, P2, 5);
        scan(3, P3, 5);
        chk("illegal_no_valid", {15'd0, valid}, 16'd0);
        scan(0, P4, 5);
        chk("illegal_then_d0", code, 16'h3214);
        chk("illegal_then_v", {15'd0, valid}, 16'd1);
        accept();

        // Unknown pattern on digit 1
        scan4(P0, PU, P2, P3);
        chk("unk_code", code, 16'h32F0);
        chk("unk_bad", {15'd0, bad}, 16'd1);
        accept();
        chk("unk_accept", {15'd0, valid}, 16'd0);
        chk("unk_bad_sticky", {15'd0, bad}, 16'd1);

        // Repeated digits restart the partial frame
        scan(0, P1, 5);
        scan(1, P2, 5);
        chk("rep_no_valid", {15'd0, valid}, 16'd0);
        scan(0, P3, 5);
        scan(1, P4, 5);
        scan(2, P5, 5);
        scan(3, P6, 5);
        chk("rep_valid", {15'd0, valid}, 16'd1);
        chk("rep_code", code, 16'h6543);

        // Completion coincides with accept of the pending frame
        scan(0, P7, 5);
        scan(1, P8, 5);
        scan(2, P9, 5);
        scan(3, P0, 4);
        chk("simul_old_code", code, 16'h6543);
        ready = 1'b1;
        scan(3, P0, 1);
        ready = 1'b0;
        chk("simul_code", code, 16'h0987);
        chk("simul_valid", {15'd0, valid}, 16'd1);
        chk("simul_ovr", {15'd0, ovr}, 16'd0);
        accept();

        // Overflow: two scans without ready
        scan4(P1, P2, P3, P4);
        chk("ovr_first", code, 16'h4321);
        chk("ovr_not_yet", {15'd0, ovr}, 16'd0);
        scan4(P5, P6, P7, P8);
        chk("ovr_held_code", code, 16'h4321);
        chk("ovr_valid", {15'd0, valid}, 16'd1);
        chk("ovr_set", {15'd0, ovr}, 16'd1);
        accept();
        chk("ovr_accept", {15'd0, valid}, 16'd0);
        chk("ovr_sticky", {15'd0, ovr}, 16'd1);

        // Reset mid-settle with a frame pending
        scan4(P2, P3, P4, P5);
        chk("rst_pre_valid", {15'd0, valid}, 16'd1);
        scan(0, P6, 3);
        rst = 1'b1;
        #1;
        chk("rst_code", code, 16'h0000);
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_bad", {15'd0, bad}, 16'd0);
        chk("rst_ovr", {15'd0, ovr}, 16'd0);
`ifdef SEG7_DP_CAPTURE_EN
        chk("rst_dp", {12'd0, dp}, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        scan(0, P9, 5);
        scan(1, P8, 5);
        scan(2, P7, 5);
        hold(4'b0111, {1'b0, P6}, 5);
        chk("post_rst_code", code, 16'h6789);
        chk("post_rst_valid", {15'd0, valid}, 16'd1);
`ifdef SEG7_DP_CAPTURE_EN
        chk("post_rst_dp", {12'd0, dp}, 16'h0008);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
